lane_player_ctrl: RTL and testbench

- Parametrised player lane controller for Lane Surfer; next generation of the 5-lane player FSM.
- Converts left/right buttons into lane moves with synchronisation, hold-to-repeat, a one-deep pending-move buffer and a pixel-animated slide between lanes.
- Drives the VGA sprite x position, the committed lane for collision logic, and a one-hot LED lane indicator.

---
 rtl/lane_pkg.sv | 20 ++
 rtl/button_conditioner.sv | 75 +++++++
 rtl/lane_player_ctrl.sv | 169 ++++++++++++++++
 tb/tb_lane_player_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lane_pkg.sv
// Shared encodings and default playfield geometry for Lane Surfer.
// The geometry constants are also used by the obstacle renderer, so the
// player and the obstacles agree on where each lane sits.
package lane_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SLIDE = 1'b1
    } state_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam int GEO_NUM_LANES = 5;
    localparam int GEO_X_ORIGIN  = 32;
    localparam int GEO_LANE_PIX  = 64;

endpackage

// File: rtl/button_conditioner.sv
// One button's input path: 2-flop synchroniser, rising-edge detect and a
// tick-based hold-to-repeat counter. The counter runs only while this
// button is held alone and the game is not frozen.
module button_conditioner
    import lane_pkg::*;
#(
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn,
    input  logic other,
    input  logic freeze,
    output logic level,
    output logic press,
    output logic rep
);

    localparam int CNT_W = $clog2(REPEAT_DELAY + 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             prev_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             rep_s;

    // Synchronise the raw button and keep the previous synchronised value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Repeat counter: after the first repeat it is rewound so the next
    // repeat lands REPEAT_RATE ticks later instead of REPEAT_DELAY.
    always_comb begin
        cnt_s = cnt_r;
        rep_s = 1'b0;
        if (freeze || !sync2_r || other) begin
            cnt_s = '0;
        end else if (tick) begin
            if (cnt_r == CNT_W'(REPEAT_DELAY - 1)) begin
                rep_s = 1'b1;
                cnt_s = CNT_W'(REPEAT_DELAY - REPEAT_RATE);
            end else begin
                cnt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Repeat counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_s;
        end
    end

    assign level = sync2_r;
    assign press = sync2_r & ~prev_r;
    assign rep   = rep_s;

endmodule

// File: rtl/lane_player_ctrl.sv
// Player lane controller: turns conditioned left/right events into lane
// moves, animates the sprite between lanes on frame ticks and keeps one
// queued move so quick taps during a slide are not lost.
module lane_player_ctrl
    import lane_pkg::*;
#(
    parameter int NUM_LANES    = GEO_NUM_LANES,
    parameter int LANE_W       = 3,
    parameter int START_LANE   = 2,
    parameter int X_W          = 10,
    parameter int X_ORIGIN     = GEO_X_ORIGIN,
    parameter int LANE_PIX     = GEO_LANE_PIX,
    parameter int STEP_PIX     = 8,
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 left,
    input  logic                 right,
    input  logic                 freeze,
    output logic [LANE_W-1:0]    lane,
    output logic [LANE_W-1:0]    target_lane,
    output logic [X_W-1:0]       x_pos,
    output logic                 moving,
    output logic                 bump,
    output logic [NUM_LANES-1:0] led_pos
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);
    localparam logic [LANE_W-1:0] INIT_LANE = LANE_W'(START_LANE);

    function automatic logic [X_W-1:0] lane_x(input logic [LANE_W-1:0] l);
        lane_x = X_W'(X_ORIGIN) + X_W'(l) * X_W'(LANE_PIX);
    endfunction

    function automatic logic [NUM_LANES-1:0] onehot(input logic [LANE_W-1:0] l);
        onehot = {{(NUM_LANES-1){1'b0}}, 1'b1} << l;
    endfunction

    logic level_l_s, level_r_s, press_l_s, press_r_s, rep_l_s, rep_r_s;
    logic ev_l_s, ev_r_s, req_l_s, req_r_s, ok_l_s, ok_r_s, bump_s;

    state_t                 state_r, state_s;
    logic [LANE_W-1:0]      lane_r, lane_s, tgt_r, tgt_s;
    logic [X_W-1:0]         x_r, x_s, goal_x_s, dist_s;
    logic                   pend_v_r, pend_v_s, bump_r;
    dir_t                   pend_dir_r, pend_dir_s;
    logic [NUM_LANES-1:0]   led_r, led_s;

    button_conditioner #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_left (
        .clk(clk), .reset(reset), .tick(tick), .btn(left), .other(level_r_s),
        .freeze(freeze), .level(level_l_s), .press(press_l_s), .rep(rep_l_s)
    );

    button_conditioner #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_right (
        .clk(clk), .reset(reset), .tick(tick), .btn(right), .other(level_l_s),
        .freeze(freeze), .level(level_r_s), .press(press_r_s), .rep(rep_r_s)
    );

    // Simultaneous events on both sides cancel; validity is judged from
    // target_lane because that is where the next move would start.
    assign ev_l_s   = press_l_s | rep_l_s;
    assign ev_r_s   = press_r_s | rep_r_s;
    assign req_l_s  = ev_l_s & ~ev_r_s & ~freeze;
    assign req_r_s  = ev_r_s & ~ev_l_s & ~freeze;
    assign ok_l_s   = req_l_s & (tgt_r != '0);
    assign ok_r_s   = req_r_s & (tgt_r != LAST_LANE);
    assign bump_s   = (req_l_s & ~ok_l_s) | (req_r_s & ~ok_r_s);
    assign goal_x_s = lane_x(tgt_r);
    assign dist_s   = (x_r > goal_x_s) ? (x_r - goal_x_s) : (goal_x_s - x_r);

    // Next-state logic for the IDLE/SLIDE machine, pending buffer and sprite x.
    always_comb begin
        state_s    = state_r;
        lane_s     = lane_r;
        tgt_s      = tgt_r;
        x_s        = x_r;
        pend_v_s   = pend_v_r;
        pend_dir_s = pend_dir_r;
        led_s      = led_r;
        case (state_r)
            IDLE: begin
                if (ok_l_s) begin
                    tgt_s   = tgt_r - LANE_W'(1);
                    state_s = SLIDE;
                end else if (ok_r_s) begin
                    tgt_s   = tgt_r + LANE_W'(1);
                    state_s = SLIDE;
                end else begin
                    state_s = IDLE;
                end
                pend_v_s = 1'b0;
            end
            SLIDE: begin
                if (ok_l_s) begin
                    pend_v_s   = 1'b1;
                    pend_dir_s = DIR_LEFT;
                end else if (ok_r_s) begin
                    pend_v_s   = 1'b1;
                    pend_dir_s = DIR_RIGHT;
                end else begin
                    pend_dir_s = pend_dir_r;
                end
                if (freeze) begin
                    pend_v_s = 1'b0;
                end else begin
                    pend_dir_s = pend_dir_s;
                end
                if (tick) begin
                    if (dist_s <= X_W'(STEP_PIX)) begin
                        x_s    = goal_x_s;
                        lane_s = tgt_r;
                        led_s  = onehot(tgt_r);
                        if (pend_v_s) begin
                            tgt_s    = (pend_dir_s == DIR_LEFT) ? (tgt_r - LANE_W'(1))
                                                                : (tgt_r + LANE_W'(1));
                            pend_v_s = 1'b0;
                        end else begin
                            state_s = IDLE;
                        end
                    end else if (x_r > goal_x_s) begin
                        x_s = x_r - X_W'(STEP_PIX);
                    end else begin
                        x_s = x_r + X_W'(STEP_PIX);
                    end
                end else begin
                    x_s = x_r;
                end
            end
            default: begin
                state_s  = IDLE;
                pend_v_s = 1'b0;
            end
        endcase
    end

    // Controller state and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            lane_r     <= INIT_LANE;
            tgt_r      <= INIT_LANE;
            x_r        <= lane_x(INIT_LANE);
            pend_v_r   <= 1'b0;
            pend_dir_r <= DIR_LEFT;
            bump_r     <= 1'b0;
            led_r      <= onehot(INIT_LANE);
        end else begin
            state_r    <= state_s;
            lane_r     <= lane_s;
            tgt_r      <= tgt_s;
            x_r        <= x_s;
            pend_v_r   <= pend_v_s;
            pend_dir_r <= pend_dir_s;
            bump_r     <= bump_s;
            led_r      <= led_s;
        end
    end

    assign lane        = lane_r;
    assign target_lane = tgt_r;
    assign x_pos       = x_r;
    assign moving      = (state_r == SLIDE);
    assign bump        = bump_r;
    assign led_pos     = led_r;

endmodule

// File: tb/tb_lane_player_ctrl.sv
// Bench for lane_player_ctrl: directed scenarios plus random button/freeze
// traffic, compared every cycle against a lane/pixel-level model.
module tb_lane_player_ctrl;

    localparam int NL = 5, X0 = 32, LP = 64, STEP = 8, RD = 30, RR = 8;

    logic       clk = 1'b0, reset = 1'b0, tick = 1'b0;
    logic       left = 1'b0, right = 1'b0, freeze = 1'b0;
    logic [2:0] lane, target_lane;
    logic [9:0] x_pos;
    logic       moving, bump;
    logic [4:0] led_pos;

    int total = 0, bad = 0;
    bit started = 1'b0, rand_tick = 1'b0;

    lane_player_ctrl dut (
        .clk(clk), .reset(reset), .tick(tick), .left(left), .right(right),
        .freeze(freeze), .lane(lane), .target_lane(target_lane), .x_pos(x_pos),
        .moving(moving), .bump(bump), .led_pos(led_pos)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int got, int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_lane, m_tgt, m_x, m_pend, nl, nr;
    bit m_mov, m_bump;
    bit [2:0] hl, hr;   // [0]=first sync stage, [1]=synchronised, [2]=previous

    function automatic bit is_rep(int n);
        return (n == RD) || (n > RD && ((n - RD) % RR) == 0);
    endfunction

    task automatic model_reset();
        m_lane = 2; m_tgt = 2; m_x = X0 + 2 * LP; m_pend = 0;
        m_mov = 1'b0; m_bump = 1'b0; nl = 0; nr = 0; hl = 3'b000; hr = 3'b000;
    endtask

    task automatic model_step();
        bit pl, pr, rl, rrp, el, er, ql, qr, nb;
        int dir, tx, d;
        pl = hl[1] && !hl[2];
        pr = hr[1] && !hr[2];
        rl = 1'b0; rrp = 1'b0;
        if (freeze || !hl[1] || hr[1]) nl = 0;
        else if (tick) begin nl++; rl = is_rep(nl); end
        if (freeze || !hr[1] || hl[1]) nr = 0;
        else if (tick) begin nr++; rrp = is_rep(nr); end
        el = pl || rl; er = pr || rrp;
        ql = el && !er && !freeze;
        qr = er && !el && !freeze;
        dir = 0; nb = 1'b0;
        if (ql) begin if (m_tgt > 0) dir = -1; else nb = 1'b1; end
        if (qr) begin if (m_tgt < NL - 1) dir = 1; else nb = 1'b1; end
        if (!m_mov) begin
            if (dir != 0) begin m_tgt += dir; m_mov = 1'b1; end
        end else begin
            if (dir != 0) m_pend = dir;
            if (freeze) m_pend = 0;
            if (tick) begin
                tx = X0 + m_tgt * LP;
                d = tx - m_x;
                if (d < 0) d = -d;
                if (d <= STEP) begin
                    m_x = tx; m_lane = m_tgt;
                    if (m_pend != 0) begin m_tgt += m_pend; m_pend = 0; end
                    else m_mov = 1'b0;
                end else begin
                    m_x += (tx > m_x) ? STEP : -STEP;
                end
            end
        end
        m_bump = nb;
        hl = {hl[1:0], left};
        hr = {hr[1:0], right};
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (started) begin
            check("lane", int'(lane), m_lane);
            check("target_lane", int'(target_lane), m_tgt);
            check("x_pos", int'(x_pos), m_x);
            check("moving", int'(moving), int'(m_mov));
            check("bump", int'(bump), int'(m_bump));
            check("led_pos", int'(led_pos), 1 << m_lane);
        end
    end

    // Frame tick: every 4 clk, or random in the stress phase.
    initial begin
        int ph = 0;
        forever begin
            @(negedge clk);
            if (rand_tick) tick = ($urandom_range(0, 2) == 0);
            else begin tick = (ph == 3); ph = (ph + 1) % 4; end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse(int which, int hold, int gap);
        if (which == 0) left = 1'b1; else right = 1'b1;
        repeat (hold) @(negedge clk);
        left = 1'b0; right = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle(int maxc);
        int k = 0;
        while (moving !== 1'b0 && k < maxc) begin @(negedge clk); k++; end
        if (k >= maxc) begin
            total++; bad++;
            $display("FAIL wait_idle timeout moving=%0d required=0", moving);
        end
    endtask

    task automatic move(int which, int n);
        for (int i = 0; i < n; i++) begin pulse(which, 3, 3); wait_idle(200); end
    endtask

    initial begin
        int bc, k;
        #1 reset = 1'b1;
        #1 started = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_lane", int'(lane), 2);
        check("rst_x", int'(x_pos), 160);
        check("rst_led", int'(led_pos), 5'b00100);
        check("rst_moving", int'(moving), 0);
        check("rst_bump", int'(bump), 0);

        // single right press: latency and full slide
        right = 1'b1;
        repeat (2) @(negedge clk);
        check("latency_early", int'(target_lane), 2);
        @(negedge clk);
        check("latency_tgt", int'(target_lane), 3);
        check("latency_moving", int'(moving), 1);
        @(negedge clk); right = 1'b0;
        repeat (3) @(negedge clk);
        wait_idle(100);
        check("slide_lane", int'(lane), 3);
        check("slide_x", int'(x_pos), 224);
        check("slide_led", int'(led_pos), 5'b01000);

        // edge bump at lane 0
        move(0, 3);
        check("at_lane0", int'(lane), 0);
        left = 1'b1; bc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 2) left = 1'b0;
            bc += int'(bump);
        end
        check("bump_count", bc, 1);
        check("bump_lane", int'(lane), 0);
        check("bump_x", int'(x_pos), 32);
        check("bump_moving", int'(moving), 0);

        // latest pending wins
        move(1, 2);
        pulse(1, 3, 5);
        pulse(0, 3, 3);
        pulse(1, 3, 3);
        check("pend_first_tgt", int'(target_lane), 3);
        wait_idle(200);
        check("pend_lane", int'(lane), 4);
        check("pend_x", int'(x_pos), 288);

        // hold-to-repeat from lane 0
        move(0, 4);
        right = 1'b1; bc = 0;
        repeat (240) begin @(negedge clk); bc += int'(bump); end
        right = 1'b0;
        wait_idle(200);
        check("hold_lane", int'(lane), 4);
        check("hold_bumps", bc, 1);

        // reset in the middle of a slide
        move(0, 2);
        pulse(1, 3, 3);
        k = 0;
        while (x_pos !== 10'd184 && k < 100) begin @(negedge clk); k++; end
        check("mid_slide_x", int'(x_pos), 184);
        #2 reset = 1'b1;
        #1;
        check("mrst_lane", int'(lane), 2);
        check("mrst_tgt", int'(target_lane), 2);
        check("mrst_x", int'(x_pos), 160);
        check("mrst_moving", int'(moving), 0);
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
        move(1, 1);
        check("post_rst_lane", int'(lane), 3);
        check("post_rst_x", int'(x_pos), 224);

        // random traffic
        for (int s = 0; s < 160; s++) begin
            rand_tick = (s >= 80);
            left   = ($urandom_range(0, 2) == 0);
            right  = ($urandom_range(0, 2) == 0);
            freeze = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 40) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk); reset = 1'b0;
            end
            repeat ($urandom_range(1, 50)) @(negedge clk);
        end
        left = 1'b0; right = 1'b0; freeze = 1'b0; rand_tick = 1'b0;
        repeat (60) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
